// File: rtl/tile_ram_arbiter_pkg.sv
// Shared constants for the tile RAM arbiter: bus widths, tile word layout and state codes.
// No logic; imported by the arbiter top and the map load sequencer.
// Widths here are defaults; the top exposes them as overridable parameters.
package tile_ram_arbiter_pkg;

  localparam int DEF_ADDR_W   = 10;   // {row[4:0], col[4:0]}
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_WAIT = 64;

  // tile word layout: [1:0] tile type, [3:2] rotation, [7:4] reserved
  localparam int TILE_TYPE_LSB = 0;
  localparam int TILE_TYPE_W   = 2;
  localparam int TILE_ROT_LSB  = 2;
  localparam int TILE_ROT_W    = 2;

  // sequencer state codes
  localparam logic ST_LOAD = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/tile_ram_arbiter_load_seq.sv
// Purpose: walks every RAM cell once after reset, turning MapData row bits into tile words.
// Latency: one cell per cycle, 1024 cycles; init_done rises one cycle after entering RUN.
// Backpressure: none -- the load owns the RAM port outright until it finishes.
module tile_load_seq
  import tile_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       map_bits,
  output logic [4:0]        map_row,
  output logic              load_active,
  output logic              in_run,
  output logic [ADDR_W-1:0] load_addr,
  output logic [DATA_W-1:0] load_din,
  output logic              init_done
);

  logic              state;
  logic [ADDR_W-1:0] cnt;

  // load counter, LOAD->RUN transition and sticky done flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == ST_LOAD) begin
      cnt <= cnt + ADDR_W'(1);
      if (cnt == {ADDR_W{1'b1}}) begin
        state <= ST_RUN;
      end
    end else begin
      init_done <= 1'b1;
    end
  end

  // Gated by reset so every RAM-side output reads 0 while reset is held,
  // even though the state register already sits in LOAD.
  assign load_active = (state == ST_LOAD) && reset;
  assign in_run      = (state == ST_RUN);
  assign load_addr   = cnt;
  assign map_row     = load_active ? cnt[9:5] : 5'd0;

  // column c lives in bit 31-c, i.e. the bitwise inverse of the 5-bit column
  always_comb begin
    load_din = '0;
    if (load_active) begin
      load_din[TILE_TYPE_LSB +: TILE_TYPE_W] = {1'b0, map_bits[~cnt[4:0]]};
      load_din[TILE_ROT_LSB +: TILE_ROT_W]   = '0;
    end
  end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Purpose: owns the single-port tile RAM; map load after reset, then video vs update arbitration.
// Latency: update ack same cycle as issue; read data (video or update) valid the following cycle.
// Backpressure: video has priority; updates hold req until ack, force-granted after MAX_WAIT denials.
module tile_ram_arbiter
  import tile_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              upd_req,
  input  logic              upd_we,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_wdata,
  output logic              upd_ack,
  output logic [DATA_W-1:0] upd_rdata,
  output logic              upd_rvalid,
  output logic [4:0]        map_row,
  input  logic [31:0]       map_bits,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic              load_active;
  logic              in_run;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_din;
  logic [ADDR_W-1:0] addr_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              force_upd;
  logic              grant_vid;
  logic              grant_upd;
  logic              vid_pend_q;
  logic              rd_pend_q;

  tile_load_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_load_seq (
    .clk         (clk),
    .reset       (reset),
    .map_bits    (map_bits),
    .map_row     (map_row),
    .load_active (load_active),
    .in_run      (in_run),
    .load_addr   (load_addr),
    .load_din    (load_din),
    .init_done   (init_done)
  );

  // one grant per cycle: starved update, then video, then normal update
  always_comb begin
    force_upd = in_run && upd_req && (wait_cnt == WAIT_W'(MAX_WAIT));
    grant_vid = in_run && vid_active && !force_upd;
    grant_upd = in_run && upd_req && !grant_vid;
  end

  assign upd_ack = grant_upd;

  // RAM port mux; an idle cycle keeps the last address on the bus
  always_comb begin
    ram_addr = addr_q;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (load_active) begin
      ram_addr = load_addr;
      ram_we   = 1'b1;
      ram_din  = load_din;
    end else if (grant_upd) begin
      ram_addr = upd_addr;
      ram_we   = upd_we;
      ram_din  = upd_wdata;
    end else if (grant_vid) begin
      ram_addr = vid_addr;
    end
  end

  // held address plus the one-cycle read-return tags for each requester
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      vid_pend_q <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      addr_q     <= ram_addr;
      vid_pend_q <= grant_vid;
      rd_pend_q  <= grant_upd && !upd_we;
    end
  end

  // Starvation counter: counts denied cycles of a live request, including
  // the load phase, so a request parked during LOAD is granted at once in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!upd_req || grant_upd) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // RAM dout is only forwarded in the cycle it belongs to that requester
  assign vid_valid  = vid_pend_q;
  assign vid_data   = vid_pend_q ? ram_dout : '0;
  assign upd_rvalid = rd_pend_q;
  assign upd_rdata  = rd_pend_q ? ram_dout : '0;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
module tb_tile_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_active;
  logic [9:0]  vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        upd_req;
  logic        upd_we;
  logic [9:0]  upd_addr;
  logic [7:0]  upd_wdata;
  logic        upd_ack;
  logic [7:0]  upd_rdata;
  logic        upd_rvalid;
  logic [4:0]  map_row;
  logic [31:0] map_bits;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = 8'h00;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] vid_q[$];
  logic [7:0] upd_q[$];
  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  tile_ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .vid_active (vid_active),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .upd_req    (upd_req),
    .upd_we     (upd_we),
    .upd_addr   (upd_addr),
    .upd_wdata  (upd_wdata),
    .upd_ack    (upd_ack),
    .upd_rdata  (upd_rdata),
    .upd_rvalid (upd_rvalid),
    .map_row    (map_row),
    .map_bits   (map_bits),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .init_done  (init_done)
  );

  // RAM_sync model: 1-cycle synchronous read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // MapData model: row0 has cols 0 and 31 set, row1 col 1 set, rest empty
  assign map_bits = (map_row == 5'd0) ? 32'h8000_0001 :
                    (map_row == 5'd1) ? 32'h4000_0000 : 32'h0000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pop the scoreboard whenever the DUT presents read data
  always @(negedge clk) begin
    if (reset) begin
      if (vid_valid) begin
        if (vid_q.size() == 0) check("vid_unexpected", vid_valid, 0);
        else check("vid_data", vid_data, vid_q.pop_front());
      end
      if (upd_rvalid) begin
        if (upd_q.size() == 0) check("upd_unexpected", upd_rvalid, 0);
        else check("upd_rdata", upd_rdata, upd_q.pop_front());
      end
    end
  end

  // runs one full map load from reset release; reports edges to init_done and first ack
  task automatic run_load(output int done_cyc, output int ack_cyc, output int vv_seen);
    done_cyc = -1;
    ack_cyc  = -1;
    vv_seen  = 0;
    for (int n = 1; n <= 1100 && done_cyc < 0; n++) begin
      @(posedge clk); #1;
      if (ack_cyc > 0) upd_req = 1'b0;
      @(negedge clk);
      if (upd_ack && ack_cyc < 0) ack_cyc = n;
      if (vid_valid) vv_seen++;
      if (init_done && done_cyc < 0) done_cyc = n;
      if (n == 31) begin
        check("load_addr31", ram_addr, 10'd31);
        check("load_din31", ram_din, 8'h01);
      end
      if (n == 33) begin
        check("load_din33", ram_din, 8'h01);
        check("load_row33", map_row, 5'd1);
      end
    end
  endtask

  task automatic vid_read(input logic [9:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    vid_active = 1'b1;
    vid_addr   = a;
    vid_q.push_back(exp);
    @(posedge clk); #1;
    vid_active = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  logic [9:0] wa [4];
  logic [7:0] wd [4];
  int done_cyc, ack_cyc, vv_seen;

  initial begin
    wa[0] = 10'h100; wa[1] = 10'h101; wa[2] = 10'h102; wa[3] = 10'h103;
    wd[0] = 8'h05;   wd[1] = 8'h0A;   wd[2] = 8'h0F;   wd[3] = 8'hC3;

    reset = 1'b0; vid_active = 1'b0; vid_addr = '0;
    upd_req = 1'b0; upd_we = 1'b0; upd_addr = '0; upd_wdata = '0;

    // reset state, with an update write already pending
    repeat (5) @(posedge clk);
    #1;
    upd_req = 1'b1; upd_we = 1'b1; upd_addr = 10'h021; upd_wdata = 8'h06;
    #1;
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_init_done", init_done, 0);
    check("rst_upd_ack", upd_ack, 0);
    check("rst_vid_valid", vid_valid, 0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("load0_we", ram_we, 1);
    check("load0_din", ram_din, 8'h01);

    run_load(done_cyc, ack_cyc, vv_seen);
    check("init_done_cycle", done_cyc, 1025);
    check("held_ack_cycle", ack_cyc, 1024);
    check("load_no_vid_valid", vv_seen, 0);
    upd_req = 1'b0;

    // map contents and the update written at RUN entry
    vid_read(10'h000, 8'h01);
    vid_read(10'h001, 8'h00);
    vid_read(10'h01E, 8'h00);
    vid_read(10'h01F, 8'h01);
    vid_read(10'h020, 8'h00);
    vid_read(10'h021, 8'h06);
    vid_read(10'h3FF, 8'h00);
    repeat (2) @(posedge clk);

    // continuous video: short cancelled write, then a starved read
    @(posedge clk); #1;
    vid_active = 1'b1; vid_addr = 10'h000;
    for (int j = 1; j <= 75; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      upd_req   = (j <= 3) || (j >= 6 && j <= 70);
      upd_we    = (j <= 3);
      upd_addr  = (j <= 3) ? 10'h000 : 10'h021;
      upd_wdata = 8'hFF;
      @(negedge clk);
      check("starve_ack", upd_ack, (j == 70));
      if (j <= 5) check("cancel_no_write", ram_we, 0);
      if (j == 70) upd_q.push_back(8'h06);
      else vid_q.push_back(8'h01);
      if (j == 71) begin
        check("force_vid_valid", vid_valid, 0);
        check("force_upd_rvalid", upd_rvalid, 1);
      end
    end
    @(posedge clk); #1;
    vid_active = 1'b0;
    upd_req = 1'b0;
    vid_read(10'h000, 8'h01);

    // back-to-back writes with video idle
    @(posedge clk); #1;
    upd_req = 1'b1; upd_we = 1'b1; upd_addr = wa[0]; upd_wdata = wd[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ack", upd_ack, 1);
      @(posedge clk); #1;
      if (i < 3) begin
        upd_addr = wa[i+1]; upd_wdata = wd[i+1];
      end else begin
        upd_req = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) vid_read(wa[i], wd[i]);
    repeat (3) @(posedge clk);

    // reset mid-run, then again mid-load at c=500
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("runrst_init_done", init_done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 500; n++) @(negedge clk);
    check("c500_addr", ram_addr, 10'd500);
    check("c500_row", map_row, 5'd15);
    check("c500_we", ram_we, 1);
    #1;
    reset = 1'b0;
    #1;
    check("abort_we", ram_we, 0);
    check("abort_addr", ram_addr, 0);
    check("abort_row", map_row, 0);
    check("abort_init_done", init_done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_load(done_cyc, ack_cyc, vv_seen);
    check("reload_done_cycle", done_cyc, 1025);
    check("reload_no_ack", ack_cyc, -1);

    vid_read(10'h021, 8'h01);
    vid_read(10'h100, 8'h00);
    vid_read(10'h000, 8'h01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("vid_q_drained", vid_q.size(), 0);
    check("upd_q_drained", upd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
